serial_addsub_ctrl: RTL

SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

---
 rtl/addsub_pkg.sv | 17 +
 rtl/addsub_slice.sv | 25 ++
 rtl/serial_addsub_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the serial add/subtract controller.
// Holds the FSM state encoding, slice width and counter sizing helper.
package addsub_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational 4-bit ripple slice built from full-adder cells.
// Ports: a, b_inv (already conditionally inverted), cin -> sum, cout.
module addsub_slice
    import addsub_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b_inv,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b_inv[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b_inv[i]) |
                          (w_c[i] & (a[i] ^ b_inv[i]));
    end

    assign cout = w_c[SLICE_W];

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Nibble-serial adder/subtractor with valid/ready start and result handshakes.
// Ports: clk, rst_n, start_valid/ready, op_sub, a, b in; res_valid/ready,
//        result, cbout, overflow, busy out. Operand width W = 4*NIBBLES.
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic                       op_sub,
    input  logic [SLICE_W*NIBBLES-1:0] a,
    input  logic [SLICE_W*NIBBLES-1:0] b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [SLICE_W*NIBBLES-1:0] result,
    output logic                       cbout,
    output logic                       overflow,
    output logic                       busy
);

    localparam int W  = SLICE_W * NIBBLES;
    localparam int CW = cnt_width(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_t r_state;
    state_t w_next;

    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_result;
    logic               r_op;
    logic               r_carry;
    logic               r_cbout;
    logic               r_ovf;
    logic [CW-1:0]      r_cnt;

    logic [SLICE_W-1:0] w_a_nib;
    logic [SLICE_W-1:0] w_b_nib;
    logic [SLICE_W-1:0] w_sum;
    logic               w_cout;
    logic               w_last;
    logic               w_accept;

    assign start_ready = rst_n && (r_state == S_IDLE);
    assign w_accept    = start_valid && start_ready;
    assign w_last      = (r_cnt == LAST);

    // Operand nibble selection; B is inverted for subtract, carry-in
    // of the first slice supplies the +1.
    always_comb begin
        w_a_nib = r_a[int'(r_cnt)*SLICE_W +: SLICE_W];
        w_b_nib = r_b[int'(r_cnt)*SLICE_W +: SLICE_W] ^ {SLICE_W{r_op}};
    end

    addsub_slice u_slice (
        .a     (w_a_nib),
        .b_inv (w_b_nib),
        .cin   (r_carry),
        .sum   (w_sum),
        .cout  (w_cout)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CALC;
            S_CALC:  if (w_last) w_next = S_DONE;
            S_DONE:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cbout  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op_sub;
            r_cnt   <= '0;
            r_carry <= op_sub;
        end else if (r_state == S_CALC) begin
            r_result[int'(r_cnt)*SLICE_W +: SLICE_W] <= w_sum;
            r_carry <= w_cout;
            if (w_last) begin
                // Flags latch only on the final slice so they stay
                // frozen for the whole DONE phase.
                r_cbout <= w_cout;
                r_ovf   <= (r_a[W-1] == (r_b[W-1] ^ r_op)) &&
                           (w_sum[SLICE_W-1] != r_a[W-1]);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign res_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;
    assign cbout     = r_cbout;
    assign overflow  = r_ovf;

endmodule
